// File: rtl/park_pkg.sv
// Shared definitions for the parking session timer: state encodings, BCD digit width,
// default session limit and a two-digit BCD incrementer.
package park_pkg;

  localparam int unsigned BCD_W       = 4;
  localparam int unsigned MAX_MIN_DEF = 99;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Binary 0..99 to two BCD digits; only used on elaboration constants.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned v);
    return {BCD_W'(v / 10), BCD_W'(v % 10)};
  endfunction

  // Two-digit BCD increment; bit 2*BCD_W flags the wrap back to 00 past tens_max:9.
  function automatic logic [2*BCD_W:0] bcd_inc(input logic [2*BCD_W-1:0] v,
                                               input logic [BCD_W-1:0]   tens_max);
    logic [2*BCD_W:0] r;
    r = {1'b0, v};
    if (v[BCD_W-1:0] != BCD_W'(9)) begin
      r[BCD_W-1:0] = v[BCD_W-1:0] + BCD_W'(1);
    end else begin
      r[BCD_W-1:0] = '0;
      if (v[2*BCD_W-1:BCD_W] != tens_max) begin
        r[2*BCD_W-1:BCD_W] = v[2*BCD_W-1:BCD_W] + BCD_W'(1);
      end else begin
        r[2*BCD_W-1:BCD_W] = '0;
        r[2*BCD_W]         = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/park_session_timer_tick_sync.sv
// tick_sync: brings the 1 Hz square wave into the clk domain and emits one registered
// pulse per rising edge, three clocks after the edge.
module tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_1hz,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q,  edge_d;
  logic seen_q,  seen_d;
  logic armed_q, armed_d;
  logic tick_q,  tick_d;

  // A level that was already high at reset release must not count as an edge:
  // arm only after a genuine low sample has passed through the first stage.
  always_comb begin
    sync1_d = clk_1hz;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    seen_d  = 1'b1;
    armed_d = armed_q | (seen_q & ~sync1_q);
    tick_d  = armed_q & sync2_q & ~edge_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      seen_q  <= 1'b0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
      seen_q  <= seen_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/park_session_timer.sv
// Parking session timer: session FSM plus saturating BCD mm:ss counter driven by 1 Hz ticks.
// Optional warn output is built when PARK_WARN_EN is defined.
module park_session_timer
  import park_pkg::*;
#(
  parameter int unsigned MAX_MIN = MAX_MIN_DEF
`ifdef PARK_WARN_EN
  , parameter int unsigned WARN_MIN = 5
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_1hz,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  output logic                 tick,
  output logic [2*BCD_W-1:0]   sec_bcd,
  output logic [2*BCD_W-1:0]   min_bcd,
  output logic                 running,
  output logic                 expired
`ifdef PARK_WARN_EN
  , output logic               warn
`endif
);

  localparam int unsigned CNT_W = 2 * BCD_W;
  localparam logic [CNT_W-1:0] MAX_BCD  = to_bcd(MAX_MIN);
  localparam logic [CNT_W-1:0] LAST_BCD = to_bcd(MAX_MIN - 1);
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(8'h59);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sec_q, sec_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic [CNT_W:0]   sec_nxt;
  logic [CNT_W:0]   min_nxt;
  logic             at_last;

  tick_sync u_tick_sync (
    .clk     (clk),
    .reset   (reset),
    .clk_1hz (clk_1hz),
    .tick    (tick)
  );

  // Next state and count; clear is applied last so it overrides everything.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    sec_nxt = bcd_inc(sec_q, BCD_W'(5));
    min_nxt = bcd_inc(min_q, BCD_W'(9));
    at_last = (min_q == LAST_BCD) && (sec_q == SEC_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          sec_d   = '0;
          min_d   = '0;
        end
      end
      ST_RUN: begin
        // Reaching the limit ends the session even if stop arrives on the same tick.
        if (tick && at_last) begin
          state_d = ST_EXPIRED;
          sec_d   = '0;
          min_d   = MAX_BCD;
        end else begin
          if (tick) begin
            sec_d = sec_nxt[CNT_W-1:0];
            if (sec_nxt[CNT_W]) begin
              min_d = min_nxt[CNT_W-1:0];
            end
          end
          if (stop) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        state_d = ST_EXPIRED;
      end
    endcase

    if (clear) begin
      state_d = ST_IDLE;
      sec_d   = '0;
      min_d   = '0;
    end

    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

`ifdef PARK_WARN_EN
  logic warn_q, warn_d;

  always_comb begin
    warn_d = ((state_d == ST_RUN) || (state_d == ST_HOLD)) &&
             ((int'(min_d[CNT_W-1:BCD_W]) * 10 + int'(min_d[BCD_W-1:0])) >=
              (int'(MAX_MIN) - int'(WARN_MIN)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sec_q     <= '0;
      min_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign sec_bcd = sec_q;
  assign min_bcd = min_q;
  assign running = running_q;
  assign expired = expired_q;

endmodule
